dma_master: RTL and testbench

//  Device-side DMA initiator: the requesting end of the memory-bus DMA port (dma_req/dma_ack/dma_rd/dma_wr).

---
 rtl/dma_master_pkg.sv | 24 ++
 rtl/dma_master_watchdog.sv | 28 ++
 rtl/dma_master.sv | 193 +++++++++++++++++++
 tb/tb_dma_master.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_master_pkg.sv
// Shared state encoding and constants for the dma_master DMA initiator.
package dma_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WGET = 3'd1,
    ST_WREQ = 3'd2,
    ST_RREQ = 3'd3,
    ST_RCAP = 3'd4,
    ST_RPUT = 3'd5,
    ST_FIN  = 3'd6
  } dma_state_e;

  localparam logic DMA_DIR_WR = 1'b0;
  localparam logic DMA_DIR_RD = 1'b1;

  // Word-addressed transfers advance the byte address by one 16-bit word.
  localparam int unsigned DMA_ADDR_INC = 2;

  function automatic logic is_bus_state(input dma_state_e s);
    return (s == ST_WREQ) || (s == ST_RREQ);
  endfunction

endpackage

// File: rtl/dma_master_watchdog.sv
// Bus-grant watchdog: counts consecutive waiting cycles and flags the TIMEOUT-th one.
module dma_master_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arm,
  output logic expire_c
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wait_cnt;

  assign expire_c = arm && (wait_cnt == WD_W'(TIMEOUT - 1));

  // Any cycle without a pending request restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (arm && !expire_c) begin
      wait_cnt <= wait_cnt + WD_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/dma_master.sv
// Device-side DMA initiator moving 16-bit words between a device stream and RAM.
// Optional bus-grant watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_master
  import dma_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              irq,
  input  logic              irq_clr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [CNT_W-1:0]  words_left,
  input  logic [DATA_W-1:0] dev_wdata,
  input  logic              dev_wvalid,
  output logic              dev_wready,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_rvalid,
  input  logic              dev_rready,
  output logic              dma_req,
  input  logic              dma_ack,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out,
  output logic              dma_rd,
  output logic              dma_wr
);

  dma_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] hold, hold_nxt;
  logic              irq_nxt, error_nxt;
  logic              abort_c;
  logic              last_word_c;
  logic              timeout_c;

`ifdef DMA_TIMEOUT_EN
  logic wd_arm_c;

  assign wd_arm_c = is_bus_state(state) && !dma_ack;

  dma_master_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .arm      (wd_arm_c),
    .expire_c (timeout_c)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_c      = 1'b0;
`endif

  // RAM strobes are gated by the grant so a chip-enable can OR them in directly.
  assign dma_rd      = dma_ack && (state == ST_RREQ);
  assign dma_wr      = dma_ack && (state == ST_WREQ);
  assign dma_addr    = cur_addr;
  assign dma_data_in = hold;
  assign dev_rdata   = hold;

  assign abort_c     = cmd_abort && (state != ST_IDLE);
  assign last_word_c = (words_left == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    addr_nxt  = cur_addr;
    count_nxt = words_left;
    hold_nxt  = hold;
    irq_nxt   = irq && !irq_clr;
    error_nxt = error;

    case (state)
      ST_IDLE: begin
        if (cmd_start && !cmd_abort) begin
          addr_nxt  = {cmd_addr[ADDR_W-1:1], 1'b0};
          count_nxt = cmd_count;
          irq_nxt   = 1'b0;
          error_nxt = 1'b0;
          if (cmd_count == '0) begin
            state_nxt = ST_FIN;
          end else if (cmd_dir == DMA_DIR_RD) begin
            state_nxt = ST_RREQ;
          end else begin
            state_nxt = ST_WGET;
          end
        end
      end
      ST_WGET: begin
        if (dev_wvalid) begin
          hold_nxt  = dev_wdata;
          state_nxt = ST_WREQ;
        end
      end
      ST_WREQ: begin
        if (dma_ack) begin
          addr_nxt  = cur_addr + ADDR_W'(DMA_ADDR_INC);
          count_nxt = words_left - CNT_W'(1);
          state_nxt = last_word_c ? ST_FIN : ST_WGET;
        end else if (timeout_c) begin
          error_nxt = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_RREQ: begin
        if (dma_ack) begin
          state_nxt = ST_RCAP;
        end else if (timeout_c) begin
          error_nxt = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_RCAP: begin
        hold_nxt  = dma_data_out;
        state_nxt = ST_RPUT;
      end
      ST_RPUT: begin
        if (dev_rready) begin
          addr_nxt  = cur_addr + ADDR_W'(DMA_ADDR_INC);
          count_nxt = words_left - CNT_W'(1);
          state_nxt = last_word_c ? ST_FIN : ST_RREQ;
        end
      end
      ST_FIN: begin
        irq_nxt   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort discards this cycle's progress; a granted access still completes on the bus.
    if (abort_c) begin
      state_nxt = ST_IDLE;
      addr_nxt  = cur_addr;
      count_nxt = words_left;
      hold_nxt  = hold;
      irq_nxt   = irq && !irq_clr;
      error_nxt = error;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered handshake outputs follow the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr   <= '0;
      words_left <= '0;
      hold       <= '0;
      irq        <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dma_req    <= 1'b0;
      dev_wready <= 1'b0;
      dev_rvalid <= 1'b0;
    end else begin
      cur_addr   <= addr_nxt;
      words_left <= count_nxt;
      hold       <= hold_nxt;
      irq        <= irq_nxt;
      error      <= error_nxt;
      busy       <= (state_nxt != ST_IDLE);
      done       <= (state == ST_FIN) && !abort_c;
      dma_req    <= is_bus_state(state_nxt);
      dev_wready <= (state_nxt == ST_WGET);
      dev_rvalid <= (state_nxt == ST_RPUT);
    end
  end

endmodule

// File: tb/tb_dma_master.sv
// Randomized self-checking bench for dma_master: bench-side RAM, device and bus models.
module tb_dma_master;

  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_start, cmd_abort, cmd_dir;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_count;
  logic          busy, done, error, irq, irq_clr;
  logic [AW-1:0] cur_addr;
  logic [CW-1:0] words_left;
  logic [DW-1:0] dev_wdata, dev_rdata;
  logic          dev_wvalid, dev_wready, dev_rvalid, dev_rready;
  logic          dma_req, dma_ack, dma_rd, dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_data_in, dma_data_out;

  always #5 clk = ~clk;

  dma_master dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_start    (cmd_start),
    .cmd_abort    (cmd_abort),
    .cmd_dir      (cmd_dir),
    .cmd_addr     (cmd_addr),
    .cmd_count    (cmd_count),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .irq          (irq),
    .irq_clr      (irq_clr),
    .cur_addr     (cur_addr),
    .words_left   (words_left),
    .dev_wdata    (dev_wdata),
    .dev_wvalid   (dev_wvalid),
    .dev_wready   (dev_wready),
    .dev_rdata    (dev_rdata),
    .dev_rvalid   (dev_rvalid),
    .dev_rready   (dev_rready),
    .dma_req      (dma_req),
    .dma_ack      (dma_ack),
    .dma_addr     (dma_addr),
    .dma_data_in  (dma_data_in),
    .dma_data_out (dma_data_out),
    .dma_rd       (dma_rd),
    .dma_wr       (dma_wr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ram [int];
  logic [15:0] ref_mem [int];
  logic [15:0] wq[$], rxq[$], wlist[$];

  int   cyc, n_ack, n_wr, n_rd, n_done, first_done, viol, abort_cyc;
  int   ack_pct, wv_pct, rr_pct, stall_left, irq_clr_at, abort_on_ack, rd_addr;
  bit   start_req, abort_now, inject_start, rd_pending, req_seen, prev_ack, held_valid;
  logic [15:0] held_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ram_val(input int a);
    if (ram.exists(a)) return ram[a];
    return 16'(a ^ 32'h5A5A);
  endfunction

  function automatic logic [15:0] ref_val(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 16'(a ^ 32'h5A5A);
  endfunction

  task automatic env_clear();
    wq.delete(); rxq.delete();
    cyc = 0; n_ack = 0; n_wr = 0; n_rd = 0; n_done = 0; first_done = -1; viol = 0;
    abort_cyc = -1; ack_pct = 60; wv_pct = 60; rr_pct = 60; stall_left = 0;
    irq_clr_at = -1; abort_on_ack = -1; rd_addr = 0;
    start_req = 0; abort_now = 0; inject_start = 0; rd_pending = 0;
    req_seen = 0; prev_ack = 0; held_valid = 0; held_data = '0;
  endtask

  // One clock of the environment: drive after the edge, observe at the falling edge.
  task automatic tick();
    dma_data_out = rd_pending ? ram_val(rd_addr) : 16'($urandom);
    rd_pending   = 1'b0;
    dma_ack      = dma_req && (int'($urandom_range(99)) < ack_pct);
    dev_wvalid   = (wq.size() > 0) && (int'($urandom_range(99)) < wv_pct);
    dev_wdata    = (wq.size() > 0) ? wq[0] : 16'($urandom);
    if (stall_left > 0 && dev_rvalid) begin
      dev_rready = 1'b0;
      stall_left--;
    end else begin
      dev_rready = int'($urandom_range(99)) < rr_pct;
    end
    irq_clr   = (cyc == irq_clr_at);
    cmd_start = start_req; start_req = 0;
    cmd_abort = abort_now; abort_now = 0;
    if (dma_ack && abort_on_ack == n_ack) begin
      cmd_abort = 1'b1;
      abort_cyc = cyc;
    end
    if (inject_start && cyc == 3 && busy) begin
      cmd_start = 1'b1;
      cmd_dir   = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_count = CW'($urandom);
    end
    @(negedge clk);
    if (dma_wr) begin n_wr++; ram[int'(dma_addr)] = dma_data_in; end
    if (dma_rd) begin n_rd++; rd_pending = 1'b1; rd_addr = int'(dma_addr); end
    if ((dma_wr || dma_rd) && !dma_ack) viol++;
    if (dma_wr && dma_rd) viol++;
    if (prev_ack && dma_req) viol++;
    prev_ack = dma_ack;
    if (dma_ack) n_ack++;
    if (dma_req) req_seen = 1'b1;
    if (dev_wvalid && dev_wready) wq.delete(0);
    if (dev_rvalid && held_valid && dev_rdata !== held_data) viol++;
    if (dev_rvalid && dev_rready) begin
      rxq.push_back(dev_rdata);
      held_valid = 1'b0;
    end else begin
      held_valid = dev_rvalid;
      held_data  = dev_rdata;
    end
    if (done) begin
      n_done++;
      if (first_done < 0) first_done = cyc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Full transfer against the reference: expected RAM image or device stream built up front.
  task automatic xfer(input string tag, input bit dir, input int addr, input int cnt);
    int          a0;
    int          wa[$];
    logic [15:0] exp_rx[$];
    logic [15:0] w;
    a0 = addr & (AMASK & ~1);
    for (int i = 0; i < cnt; i++) begin
      int ai;
      ai = (a0 + 2 * i) & AMASK;
      if (!dir) begin
        w = (wlist.size() > i) ? wlist[i] : 16'($urandom);
        wq.push_back(w);
        ref_mem[ai] = w;
        wa.push_back(ai);
      end else begin
        exp_rx.push_back(ref_val(ai));
      end
    end
    cmd_dir = dir; cmd_addr = AW'(addr); cmd_count = CW'(cnt);
    start_req = 1'b1; cyc = 0;
    while (n_done == 0 && cyc < 3000) tick();
    repeat (3) tick();
    chk({tag, ":done_cnt"}, n_done, 1);
    chk({tag, ":irq"}, irq, 1);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":error"}, error, 0);
    chk({tag, ":words_left"}, words_left, 0);
    chk({tag, ":cur_addr"}, cur_addr, (a0 + 2 * cnt) & AMASK);
    chk({tag, ":wr_pulses"}, n_wr, dir ? 0 : cnt);
    chk({tag, ":rd_pulses"}, n_rd, dir ? cnt : 0);
    chk({tag, ":protocol"}, viol, 0);
    chk({tag, ":ram_size"}, ram.num(), ref_mem.num());
    foreach (wa[i]) chk($sformatf("%s:ram%0d", tag, i), ram_val(wa[i]), ref_val(wa[i]));
    if (dir) begin
      chk({tag, ":rx_cnt"}, rxq.size(), exp_rx.size());
      foreach (exp_rx[i])
        if (i < rxq.size()) chk($sformatf("%s:rx%0d", tag, i), rxq[i], exp_rx[i]);
    end
    if (cnt == 0) begin
      chk({tag, ":done_lat"}, first_done, 2);
      chk({tag, ":no_req"}, req_seen, 0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    cmd_start = 0; cmd_abort = 0; cmd_dir = 0; cmd_addr = '0; cmd_count = '0;
    irq_clr = 0; dev_wdata = '0; dev_wvalid = 0; dev_rready = 0;
    dma_ack = 0; dma_data_out = '0;
    env_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:error", error, 0);
    chk("rst:irq", irq, 0);
    chk("rst:cur_addr", cur_addr, 0);
    chk("rst:words_left", words_left, 0);
    chk("rst:bus", {dma_req, dma_rd, dma_wr, dev_wready, dev_rvalid}, 0);
    chk("rst:data", {dev_rdata, dma_data_in}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed write of three words.
    env_clear();
    wlist = '{16'h1111, 16'h2222, 16'h3333};
    xfer("wr3", 1'b0, 'o1000, 3);
    wlist.delete();
    chk("wr3:m0", ram_val('o1000), 16'h1111);
    chk("wr3:m1", ram_val('o1002), 16'h2222);
    chk("wr3:m2", ram_val('o1004), 16'h3333);

    // Directed read with the device stalling the first word.
    ram['o2000] = 16'hABCD; ram['o2002] = 16'h1234;
    ref_mem['o2000] = 16'hABCD; ref_mem['o2002] = 16'h1234;
    env_clear();
    stall_left = 5;
    xfer("rd2", 1'b1, 'o2000, 2);
    chk("rd2:w0", (rxq.size() > 0) ? rxq[0] : 16'h0, 16'hABCD);
    chk("rd2:w1", (rxq.size() > 1) ? rxq[1] : 16'h0, 16'h1234);
    chk("rd2:addr", cur_addr, 'o2004);

    // Null transfer, irq_clr coinciding with the finish cycle.
    env_clear();
    irq_clr_at = 1;
    xfer("nul", 1'b0, 'o4000, 0);
    env_clear();
    irq_clr_at = 0;
    tick();
    chk("irqclr:irq", irq, 0);

    // Address wrap at the top of memory.
    env_clear();
    xfer("wrap", 1'b0, 'o777776, 2);
    chk("wrap:m0", ram_val('o777776), ref_val('o777776));
    chk("wrap:m1", ram_val(0), ref_val(0));

    // Start together with abort while idle: start must be ignored.
    env_clear();
    cmd_dir = 1'b0; cmd_addr = AW'('o6000); cmd_count = CW'(2);
    start_req = 1'b1; abort_now = 1'b1;
    repeat (3) tick();
    chk("sa:busy", busy, 0);
    chk("sa:req", req_seen, 0);
    chk("sa:done", n_done, 0);
    chk("sa:irq", irq, 1);

    // Abort in the grant cycle of the second word.
    env_clear();
    begin
      logic [15:0] w0, w1, w2;
      w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
      wq.push_back(w0); wq.push_back(w1); wq.push_back(w2);
      ref_mem['o10000] = w0; ref_mem['o10002] = w1;
      abort_on_ack = 1;
      cmd_dir = 1'b0; cmd_addr = AW'('o10000); cmd_count = CW'(3);
      start_req = 1'b1; cyc = 0;
      while (abort_cyc < 0 && cyc < 3000) tick();
      chk("abt:seen", abort_cyc >= 0, 1);
      chk("abt:busy", busy, 0);
      chk("abt:req", dma_req, 0);
      chk("abt:words_left", words_left, 2);
      chk("abt:cur_addr", cur_addr, 'o10002);
      wq.delete();
      repeat (5) tick();
      chk("abt:done", n_done, 0);
      chk("abt:irq", irq, 0);
      chk("abt:wr_pulses", n_wr, 2);
      chk("abt:landed", ram_val('o10002), w1);
      chk("abt:ram_size", ram.num(), ref_mem.num());
      chk("abt:protocol", viol, 0);
    end

    // Reset pulse in the middle of a read, with the grant high.
    env_clear();
    ack_pct = 0;
    cmd_dir = 1'b1; cmd_addr = AW'('o3000); cmd_count = CW'(4);
    start_req = 1'b1;
    repeat (4) tick();
    chk("rstm:req", dma_req, 1);
    dma_ack = 1'b1;
    #1;
    chk("rstm:rd_pre", dma_rd, 1);
    reset_n = 1'b0;
    #1;
    chk("rstm:rd", dma_rd, 0);
    chk("rstm:req0", dma_req, 0);
    chk("rstm:outs", {busy, done, error, irq, dev_wready, dev_rvalid, dma_wr}, 0);
    chk("rstm:addr", cur_addr, 0);
    chk("rstm:left", words_left, 0);
    dma_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    env_clear();

    // Bus never granted.
    env_clear();
    ack_pct = 0;
    wq.push_back(16'hBEEF);
    cmd_dir = 1'b0; cmd_addr = AW'('o5000); cmd_count = CW'(1);
    start_req = 1'b1;
    repeat (1000) tick();
`ifdef DMA_TIMEOUT_EN
    chk("nto:error", error, 1);
    chk("nto:done", n_done, 1);
    chk("nto:left", words_left, 1);
`else
    chk("nto:busy", busy, 1);
    chk("nto:req", dma_req, 1);
    chk("nto:error", error, 0);
    chk("nto:done", n_done, 0);
    abort_now = 1'b1;
    tick();
    chk("nto:abort_busy", busy, 0);
    chk("nto:abort_req", dma_req, 0);
    chk("nto:abort_left", words_left, 1);
`endif

    // Randomized transfers against the reference image.
    for (int t = 0; t < 24; t++) begin
      bit d;
      int a, c;
      env_clear();
      ack_pct      = int'($urandom_range(100, 20));
      wv_pct       = int'($urandom_range(100, 20));
      rr_pct       = int'($urandom_range(100, 20));
      inject_start = 1'($urandom_range(1));
      d = 1'($urandom_range(1));
      a = ($urandom_range(3) == 0) ? (AMASK - 2 * int'($urandom_range(3))) : (int'($urandom) & AMASK);
      c = int'($urandom_range(6));
      xfer($sformatf("rnd%0d", t), d, a, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
